// File: rtl/inst_fetch.sv
// ============================================================================
// inst_fetch : single-issue instruction fetch stage with redirect and halt.
// Rev 1.0
// ============================================================================
`default_nettype none

module inst_fetch #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter logic [7:0] LAST_PC  = 8'h4C
) (
  input  logic        clk,
  input  logic        rst,
  output logic [7:0]  imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [7:0]  redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [7:0]  id_pc,
  output logic        halted,
  output logic        misalign_err,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [7:0]  id_pc_q, id_pc_d;
  logic        misalign_q, misalign_d;
  logic [15:0] fetch_count_q, fetch_count_d;

  logic [7:0]  redir_target;
  logic        load_en;

  assign redir_target = {redirect_pc[7:2], 2'b00};
  // Redirect wins over a load, so a load only happens on a quiet FETCH cycle.
  assign load_en = (state_q == S_FETCH) && !redirect_valid && (!id_valid_q || id_ready);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    id_valid_d    = id_valid_q;
    id_instr_d    = id_instr_q;
    id_pc_d       = id_pc_q;
    misalign_d    = misalign_q;
    fetch_count_d = fetch_count_q;

    if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      misalign_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        if (redirect_valid) begin
          pc_d = redir_target;
        end
        if (id_ready) begin
          id_valid_d = 1'b0;
        end
      end

      S_FETCH, S_HALT: begin
        if (redirect_valid) begin
          id_valid_d = 1'b0;
          pc_d       = redir_target;
          state_d    = S_FETCH;
        end else if (load_en) begin
          id_instr_d = imem_instr;
          id_pc_d    = pc_q;
          id_valid_d = 1'b1;
          pc_d       = pc_q + 8'd4;
          if (fetch_count_q != 16'hFFFF) begin
            fetch_count_d = fetch_count_q + 16'd1;
          end
          if (pc_q == LAST_PC) begin
            state_d = S_HALT;
          end
        end else if ((state_q == S_HALT) && id_ready) begin
          id_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      id_valid_q    <= 1'b0;
      id_instr_q    <= 32'h0;
      id_pc_q       <= 8'h0;
      misalign_q    <= 1'b0;
      fetch_count_q <= 16'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      id_valid_q    <= id_valid_d;
      id_instr_q    <= id_instr_d;
      id_pc_q       <= id_pc_d;
      misalign_q    <= misalign_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_addr    = pc_q;
  assign id_valid     = id_valid_q;
  assign id_instr     = id_instr_q;
  assign id_pc        = id_pc_q;
  assign halted       = (state_q == S_HALT);
  assign misalign_err = misalign_q;
  assign fetch_count  = fetch_count_q;

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch.sv
// ============================================================================
// tb_inst_fetch : directed + randomized bench with a behavioural fetch model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_inst_fetch;

  localparam logic [7:0] C_RESET_PC = 8'h00;
  localparam logic [7:0] C_LAST_PC  = 8'h4C;

  logic        clk;
  logic        rst;
  logic [7:0]  imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [7:0]  id_pc;
  logic        halted;
  logic        misalign_err;
  logic [15:0] fetch_count;

  logic [31:0] rom [0:63];
  int n_vec;
  int n_err;
  logic chk_en;

  inst_fetch #(.RESET_PC(C_RESET_PC), .LAST_PC(C_LAST_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .halted         (halted),
    .misalign_err   (misalign_err),
    .fetch_count    (fetch_count)
  );

  assign imem_instr = rom[imem_addr[7:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 = one dead cycle after reset, 1 = running,
  // 2 = program finished. Presented instruction tracked as (valid, word, addr).
  int          m_phase;
  logic [7:0]  m_pc;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [7:0]  m_idpc;
  logic        m_err;
  int          m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_pc    <= C_RESET_PC;
      m_valid <= 1'b0;
      m_instr <= 32'h0;
      m_idpc  <= 8'h0;
      m_err   <= 1'b0;
      m_cnt   <= 0;
    end else begin
      if (redirect_valid && (redirect_pc % 4 != 0)) m_err <= 1'b1;
      if (m_phase == 0) begin
        m_phase <= 1;
        if (redirect_valid) m_pc <= redirect_pc & 8'hFC;
        if (id_ready) m_valid <= 1'b0;
      end else if (redirect_valid) begin
        m_valid <= 1'b0;
        m_pc    <= redirect_pc & 8'hFC;
        m_phase <= 1;
      end else if (m_phase == 1 && (!m_valid || id_ready)) begin
        m_valid <= 1'b1;
        m_instr <= rom[m_pc / 4];
        m_idpc  <= m_pc;
        m_pc    <= 8'((int'(m_pc) + 4) % 256);
        m_cnt   <= (m_cnt < 65535) ? m_cnt + 1 : 65535;
        if (m_pc == C_LAST_PC) m_phase <= 2;
      end else if (m_phase == 2 && id_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_imem_addr", {24'h0, imem_addr}, {24'h0, m_pc});
      chk("m_id_valid", {31'h0, id_valid}, {31'h0, m_valid});
      chk("m_id_instr", id_instr, m_instr);
      chk("m_id_pc", {24'h0, id_pc}, {24'h0, m_idpc});
      chk("m_halted", {31'h0, halted}, (m_phase == 2) ? 32'h1 : 32'h0);
      chk("m_misalign", {31'h0, misalign_err}, {31'h0, m_err});
      chk("m_fetch_count", {16'h0, fetch_count}, m_cnt[31:0]);
    end
  end

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_halt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (halted) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("halt_timeout", 32'h0, 32'h1);
  endtask

  initial begin
    bit ok;
    n_vec = 0;
    n_err = 0;
    chk_en = 1'b0;
    for (int i = 0; i < 64; i++) rom[i] = 32'h00000013 | (i << 20) | (i << 7);
    rom[0]  = 32'h00007033;
    rom[1]  = 32'h00100093;
    rom[2]  = 32'h00200113;
    rom[3]  = 32'h00308193;
    rom[8]  = 32'h00208433;
    rom[9]  = 32'h404404b3;
    rom[19] = 32'h03002603;
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 8'h0;
    id_ready = 1'b1;
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_id_valid", {31'h0, id_valid}, 32'h0);
    chk("rst_imem_addr", {24'h0, imem_addr}, 32'h00);
    chk("rst_fetch_count", {16'h0, fetch_count}, 32'h0);
    rst = 1'b0;

    // Start-up latency and first two instructions.
    @(negedge clk);
    chk("c1_id_valid", {31'h0, id_valid}, 32'h0);
    @(negedge clk);
    chk("c2_id_instr", id_instr, 32'h00007033);
    chk("c2_id_pc", {24'h0, id_pc}, 32'h00);
    @(negedge clk);
    chk("c3_id_instr", id_instr, 32'h00100093);
    chk("c3_id_pc", {24'h0, id_pc}, 32'h04);
    @(negedge clk);
    chk("c4_id_pc", {24'h0, id_pc}, 32'h08);

    // Back-pressure holds the presented instruction and the PC.
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_id_instr", id_instr, 32'h00200113);
      chk("stall_imem_addr", {24'h0, imem_addr}, 32'h0C);
    end
    id_ready = 1'b1;
    @(negedge clk);
    chk("post_stall_instr", id_instr, 32'h00308193);

    // Aligned redirect flushes.
    redirect_valid = 1'b1;
    redirect_pc = 8'h20;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("redir_id_valid", {31'h0, id_valid}, 32'h0);
    chk("redir_imem_addr", {24'h0, imem_addr}, 32'h20);
    @(negedge clk);
    chk("redir_instr", id_instr, 32'h00208433);
    chk("redir_id_pc", {24'h0, id_pc}, 32'h20);

    // Misaligned redirect rounds down and latches the error.
    redirect_valid = 1'b1;
    redirect_pc = 8'h26;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("mis_imem_addr", {24'h0, imem_addr}, 32'h24);
    chk("mis_err", {31'h0, misalign_err}, 32'h1);
    @(negedge clk);
    chk("mis_instr", id_instr, 32'h404404b3);
    redirect_valid = 1'b1;
    redirect_pc = 8'h00;
    @(negedge clk);
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("mis_sticky", {31'h0, misalign_err}, 32'h1);

    // Free run to the end of the program image.
    reset_pulse();
    wait_halt(ok);
    if (ok) begin
      chk("halt_instr", id_instr, 32'h03002603);
      chk("halt_id_pc", {24'h0, id_pc}, 32'h4C);
      chk("halt_count", {16'h0, fetch_count}, 32'd20);
      chk("halt_id_valid", {31'h0, id_valid}, 32'h1);
      @(negedge clk);
      chk("halt_drain_valid", {31'h0, id_valid}, 32'h0);
      chk("halt_imem_addr", {24'h0, imem_addr}, 32'h50);
      repeat (3) @(negedge clk);
      chk("halt_stay_addr", {24'h0, imem_addr}, 32'h50);
      chk("halt_stay_count", {16'h0, fetch_count}, 32'd20);
    end

    // Asynchronous reset while halted with a held instruction.
    reset_pulse();
    wait_halt(ok);
    if (ok) begin
      #2 rst = 1'b1;
      #1;
      chk("areset_id_valid", {31'h0, id_valid}, 32'h0);
      chk("areset_halted", {31'h0, halted}, 32'h0);
      chk("areset_id_instr", id_instr, 32'h0);
      chk("areset_id_pc", {24'h0, id_pc}, 32'h0);
      chk("areset_imem_addr", {24'h0, imem_addr}, 32'h00);
      chk("areset_count", {16'h0, fetch_count}, 32'h0);
      chk("areset_misalign", {31'h0, misalign_err}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("restart_c1_valid", {31'h0, id_valid}, 32'h0);
      @(negedge clk);
      chk("restart_instr", id_instr, 32'h00007033);
      chk("restart_id_pc", {24'h0, id_pc}, 32'h00);
    end

    // Randomized traffic, checked every cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 249) == 0);
      id_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 255))
                                                 : 8'($urandom_range(0, 19) * 4);
    end
    @(negedge clk);
    rst = 1'b0;
    redirect_valid = 1'b0;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 8'h00, SHALL be the first fetch address after reset.
REQ-002 Parameter LAST_PC, default 8'h4C, SHALL be the address of the final instruction in the program image.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit, SHALL be the reset: asynchronous, active-high.
REQ-005 Port imem_addr, output, 8 bits, SHALL be the byte address to the instruction ROM, equal to the PC register.
REQ-006 Port imem_instr, input, 32 bits, SHALL be the instruction word returned combinationally for imem_addr.
REQ-007 Port redirect_valid, input, 1 bit, SHALL request a PC change (branch/jump).
REQ-008 Port redirect_pc, input, 8 bits, SHALL be the redirect target.
REQ-009 Port id_ready, input, 1 bit, SHALL indicate decode accepts the held instruction this cycle.
REQ-010 Port id_valid, output, 1 bit, SHALL indicate id_instr/id_pc hold a valid fetched instruction.
REQ-011 Port id_instr, output, 32 bits, SHALL be the registered fetched instruction.
REQ-012 Port id_pc, output, 8 bits, SHALL be the address id_instr was fetched from.
REQ-013 Port halted, output, 1 bit, SHALL be high while in HALT.
REQ-014 Port misalign_err, output, 1 bit, SHALL be a sticky flag for a non-word-aligned redirect.
REQ-015 Port fetch_count, output, 16 bits, SHALL count accepted ROM loads.

Function
REQ-016 FSM states: IDLE, FETCH, HALT; IDLE SHALL advance to FETCH after exactly one cycle with no load.
REQ-017 Load condition in FETCH SHALL be (!id_valid || id_ready) with no redirect.
REQ-018 On load: id_instr<=imem_instr, id_pc<=pc, id_valid<=1, pc<=pc+4 modulo 256 (8'hFC wraps to 8'h00).
REQ-019 With id_valid=1 and id_ready=0: pc, id_instr, id_pc and id_valid SHALL hold.
REQ-020 With id_ready=1 and no load (IDLE/HALT): id_valid SHALL clear next cycle.
REQ-021 A load at pc==LAST_PC SHALL transition FETCH->HALT; no further loads occur in HALT.
REQ-022 Redirect (FETCH or HALT) SHALL take priority over load: id_valid<=0 (flush), pc<={redirect_pc[7:2],2'b00}, state<=FETCH, ROM data that cycle discarded.
REQ-023 Redirect in IDLE SHALL update pc only; state still advances to FETCH.
REQ-024 Redirect with redirect_pc[1:0]!=0 SHALL set misalign_err, which stays set until reset.
REQ-025 fetch_count SHALL increment by 1 per load and saturate at 16'hFFFF.
REQ-026 Redirect and id_ready asserted together SHALL count as consumption plus flush; no instruction is presented twice.

Reset
REQ-027 While rst=1, regardless of clk: pc=RESET_PC, state=IDLE, id_valid=0, id_instr=32'h0, id_pc=8'h0, halted=0, misalign_err=0, fetch_count=0.
REQ-028 Reset asserted mid-operation SHALL discard any held instruction; fetch restarts per REQ-016 after rst falls.

Verification
REQ-029 Reset release, id_ready=1, lab ROM image -> cycle 1 id_valid=0; cycle 2 id_instr=32'h00007033 with id_pc=8'h00; cycle 3 id_instr=32'h00100093 with id_pc=8'h04.
REQ-030 id_ready=0 for 3 cycles while id_valid=1 at id_pc=8'h08 -> id_instr=32'h00200113 and imem_addr=8'h0C held; after id_ready=1, next id_instr=32'h00308193.
REQ-031 redirect_valid=1, redirect_pc=8'h20 while id_valid=1 -> next cycle id_valid=0, imem_addr=8'h20; following cycle id_instr=32'h00208433 with id_pc=8'h20.
REQ-032 redirect_pc=8'h26 -> pc=8'h24, misalign_err=1; next load id_instr=32'h404404b3; misalign_err stays 1 after later aligned redirects.
REQ-033 Free run from reset, id_ready=1 -> load at 8'h4C gives id_instr=32'h03002603, halted=1, fetch_count=20; id_valid=0 one cycle later; imem_addr stays 8'h50.
REQ-034 rst pulsed while halted=1 with id_valid=1 -> all outputs return to REQ-027 values immediately; fetching resumes from 8'h00.
